// File: rtl/rf_writeback_queue_if.sv
// rf_writeback_queue_if
//   Producer-to-queue result handshake for the register-file writeback queue.
//   The execute/memory stages drive a destination register and its data.
//   The queue answers with res_ready.
//
//   Signals
//     res_valid  producer has a result this cycle
//     res_ready  queue accepts the result on the next rising edge
//     res_wa     destination register address (AW bits)
//     res_wd     result data (DW bits)
//
//   Modports
//     master  producer side
//     slave   queue side
interface rf_writeback_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_wa;
    logic [DW-1:0] res_wd;

    modport master (
        output res_valid,
        output res_wa,
        output res_wd,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_wa,
        input  res_wd,
        output res_ready
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue
//   Writer side of the register-file write port. ALU and memory results are
//   buffered in a small FIFO. One entry is drained into the registered
//   rfwe/RFWA/RFWD outputs on each cycle that the controller grants the port
//   through drain_en. Writes to r0 are accepted but never queued.
//
//   Optional feature macro: RF_WB_FWD_EN
//     When this macro is defined, the module adds fwd_ra/fwd_hit/fwd_data. These
//     ports search the queue and the in-flight output register for the youngest
//     pending value of a register.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous, active-low reset
//     res_if     producer handshake (slave modport): res_valid/res_ready/res_wa/res_wd
//     drain_en   controller grants the register-file write port this cycle
//     flush      synchronous discard of all queued and in-flight writes
//     rfwe       register-file write enable (registered, one cycle per entry)
//     RFWA       register-file write address (registered, holds when idle)
//     RFWD       register-file write data (registered, holds when idle)
//     count      current queue occupancy
//     pending    queue non-empty or a write still in flight
//     fwd_ra     (RF_WB_FWD_EN) register to look up
//     fwd_hit    (RF_WB_FWD_EN) a pending write to fwd_ra exists
//     fwd_data   (RF_WB_FWD_EN) youngest pending value for fwd_ra
module rf_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    rf_writeback_queue_if.slave          res_if,
    input  logic                         drain_en,
    input  logic                         flush,
    output logic                         rfwe,
    output logic [AW-1:0]                RFWA,
    output logic [DW-1:0]                RFWD,
    output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef RF_WB_FWD_EN
    input  logic [AW-1:0]                fwd_ra,
    output logic                         fwd_hit,
    output logic [DW-1:0]                fwd_data,
`endif
    output logic                         pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rfwe_q, rfwe_d;
    logic [AW-1:0]   rfwa_q, rfwa_d;
    logic [DW-1:0]   rfwd_q, rfwd_d;

    logic            res_ready;
    logic            do_push;
    logic            do_pop;

    // res_ready is held low for the whole reset and the flush cycle. It does not
    // look ahead at a same-cycle pop, so a full queue never accepts a push.
    assign res_ready        = (count_q < DEPTH_C) && rst && !flush;
    assign res_if.res_ready = res_ready;

    // A handshake that targets r0 completes without occupying an entry.
    assign do_push = res_if.res_valid && res_ready && (res_if.res_wa != '0);
    // Pop only looks at the registered count, so a freshly pushed entry is
    // never forwarded to the outputs in the same edge.
    assign do_pop  = drain_en && (count_q != '0) && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rfwe_d   = 1'b0;
        rfwa_d   = rfwa_q;
        rfwd_d   = rfwd_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rfwe_d   = 1'b1;
                rfwa_d   = mem_q[rd_ptr_q].wa;
                rfwd_d   = mem_q[rd_ptr_q].wd;
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (do_push) begin
                mem_d[wr_ptr_q] = '{wa: res_if.res_wa, wd: res_if.res_wd};
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rfwe_q   <= 1'b0;
            rfwa_q   <= '0;
            rfwd_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rfwe_q   <= rfwe_d;
            rfwa_q   <= rfwa_d;
            rfwd_q   <= rfwd_d;
        end
    end

    assign rfwe    = rfwe_q;
    assign RFWA    = rfwa_q;
    assign RFWD    = rfwd_q;
    assign count   = count_q;
    assign pending = (count_q != '0) || rfwe_q;

`ifdef RF_WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Check the oldest source first (the output register), then walk the
    // queue from head to tail. A later match always overrides an earlier one,
    // so the youngest value wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (fwd_ra != '0) begin
            if (rfwe_q && (rfwa_q == fwd_ra)) begin
                fwd_hit  = 1'b1;
                fwd_data = rfwd_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = rd_ptr_q + PW'(i);
                if ((CW'(i) < count_q) && (mem_q[fwd_idx].wa == fwd_ra)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = mem_q[fwd_idx].wd;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue
//   Directed, table-driven bench for rf_writeback_queue. Each vector drives
//   its inputs at the falling edge. It lets one rising edge pass, then
//   compares every output 1 ns later while the vector's inputs are still
//   applied. Expected values in the table are hand-derived. Separate hand-written
//   sequences cover the reset behaviour and the optional forwarding ports.
module tb_rf_writeback_queue;

    logic        clk;
    logic        rst;
    logic        drain_en;
    logic        flush;
    logic        rfwe;
    logic [4:0]  RFWA;
    logic [31:0] RFWD;
    logic [2:0]  count;
    logic        pending;
`ifdef RF_WB_FWD_EN
    logic [4:0]  fwd_ra;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int checks;
    int errors;

    rf_writeback_queue_if #(.AW(5), .DW(32)) res_if ();

    rf_writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .res_if   (res_if),
        .drain_en (drain_en),
        .flush    (flush),
        .rfwe     (rfwe),
        .RFWA     (RFWA),
        .RFWD     (RFWD),
        .count    (count),
`ifdef RF_WB_FWD_EN
        .fwd_ra   (fwd_ra),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
`endif
        .pending  (pending)
    );

    // 10 ns free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        drain;
        logic        flush;
        logic        e_ready;
        logic        e_rfwe;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [2:0]  e_count;
        logic        e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic v, input logic [4:0] wa, input logic [31:0] wd,
        input logic dr, input logic fl, input logic er, input logic ew,
        input logic [4:0] ewa, input logic [31:0] ewd, input logic [2:0] ec,
        input logic ep);
        vec_t t;
        t.rst = r;       t.valid = v;     t.wa = wa;       t.wd = wd;
        t.drain = dr;    t.flush = fl;    t.e_ready = er;  t.e_rfwe = ew;
        t.e_wa = ewa;    t.e_wd = ewd;    t.e_count = ec;  t.e_pend = ep;
        return t;
    endfunction

    // One comparison: counts it, and reports a FAIL line on mismatch
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge, pass one rising edge, settle
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst              = v.rst;
        res_if.res_valid = v.valid;
        res_if.res_wa    = v.wa;
        res_if.res_wd    = v.wd;
        drain_en         = v.drain;
        flush            = v.flush;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVector(input string tag, input vec_t v);
        checkOutput({tag, " res_ready"}, 32'(res_if.res_ready), 32'(v.e_ready));
        checkOutput({tag, " rfwe"},      32'(rfwe),             32'(v.e_rfwe));
        checkOutput({tag, " RFWA"},      32'(RFWA),             32'(v.e_wa));
        checkOutput({tag, " RFWD"},      RFWD,                  v.e_wd);
        checkOutput({tag, " count"},     32'(count),            32'(v.e_count));
        checkOutput({tag, " pending"},   32'(pending),          32'(v.e_pend));
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;

        // Fields: rst valid wa wd drain flush | ready rfwe RFWA RFWD count pending
        // Reset release, then single push with immediate grant
        vecs.push_back(mk(1,0, 0,32'h0,      0,0, 1,0, 0,32'h0,    0,0));
        vecs.push_back(mk(1,1, 5,32'h1234,   1,0, 1,0, 0,32'h0,    1,1));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,1, 5,32'h1234, 0,1));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,0, 5,32'h1234, 0,0));
        // Fill to DEPTH with drain off. The fifth push is refused.
        vecs.push_back(mk(1,1, 1,32'h101,    0,0, 1,0, 5,32'h1234, 1,1));
        vecs.push_back(mk(1,1, 2,32'h102,    0,0, 1,0, 5,32'h1234, 2,1));
        vecs.push_back(mk(1,1, 3,32'h103,    0,0, 1,0, 5,32'h1234, 3,1));
        vecs.push_back(mk(1,1, 4,32'h104,    0,0, 0,0, 5,32'h1234, 4,1));
        vecs.push_back(mk(1,1, 5,32'h105,    0,0, 0,0, 5,32'h1234, 4,1));
        // Drain in FIFO order
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,1, 1,32'h101,  3,1));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,1, 2,32'h102,  2,1));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,1, 3,32'h103,  1,1));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,1, 4,32'h104,  0,1));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,0, 4,32'h104,  0,0));
        // Write to r0 is swallowed
        vecs.push_back(mk(1,1, 0,32'hFFFFFFFF,1,0, 1,0, 4,32'h104,  0,0));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,0, 4,32'h104,  0,0));
        // Simultaneous push and pop
        vecs.push_back(mk(1,1, 6,32'h600,    0,0, 1,0, 4,32'h104,  1,1));
        vecs.push_back(mk(1,1, 7,32'h700,    1,0, 1,1, 6,32'h600,  1,1));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,1, 7,32'h700,  0,1));
        vecs.push_back(mk(1,0, 0,32'h0,      0,0, 1,0, 7,32'h700,  0,0));
        // Full queue with a pop: the push stays blocked; pointers wrap
        vecs.push_back(mk(1,1, 8,32'h800,    0,0, 1,0, 7,32'h700,  1,1));
        vecs.push_back(mk(1,1, 9,32'h900,    0,0, 1,0, 7,32'h700,  2,1));
        vecs.push_back(mk(1,1,10,32'hA00,    0,0, 1,0, 7,32'h700,  3,1));
        vecs.push_back(mk(1,1,11,32'hB00,    0,0, 0,0, 7,32'h700,  4,1));
        vecs.push_back(mk(1,1,12,32'hC00,    1,0, 1,1, 8,32'h800,  3,1));
        // Flush with three entries queued, then grant: nothing comes out
        vecs.push_back(mk(1,0, 0,32'h0,      0,1, 0,0, 8,32'h800,  0,0));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,0, 8,32'h800,  0,0));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,0, 8,32'h800,  0,0));
        // Flush kills an in-flight write and beats a concurrent push
        vecs.push_back(mk(1,1,13,32'hD00,    0,0, 1,0, 8,32'h800,  1,1));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,1,13,32'hD00,  0,1));
        vecs.push_back(mk(1,1,14,32'hE00,    1,1, 0,0,13,32'hD00,  0,0));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,0,13,32'hD00,  0,0));
        // Same register queued twice retires oldest first
        vecs.push_back(mk(1,1, 3,32'hA,      0,0, 1,0,13,32'hD00,  1,1));
        vecs.push_back(mk(1,1, 3,32'hB,      0,0, 1,0,13,32'hD00,  2,1));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,1, 3,32'hA,    1,1));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,1, 3,32'hB,    0,1));
        vecs.push_back(mk(1,0, 0,32'h0,      1,0, 1,0, 3,32'hB,    0,0));

        // Reset held low with a valid producer
        rst              = 1'b0;
        res_if.res_valid = 1'b1;
        res_if.res_wa    = 5'd9;
        res_if.res_wd    = 32'h55;
        drain_en         = 1'b0;
        flush            = 1'b0;
`ifdef RF_WB_FWD_EN
        fwd_ra           = 5'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset res_ready", 32'(res_if.res_ready), 32'd0);
        checkOutput("reset rfwe",      32'(rfwe),             32'd0);
        checkOutput("reset count",     32'(count),            32'd0);
        checkOutput("reset pending",   32'(pending),          32'd0);
        checkOutput("reset RFWA",      32'(RFWA),             32'd0);
        checkOutput("reset RFWD",      RFWD,                  32'd0);
        res_if.res_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkVector($sformatf("vec%0d", i), vecs[i]);
        end

`ifdef RF_WB_FWD_EN
        // Two writes to r7 queued: the youngest value is forwarded
        v = mk(1,1, 7,32'h11, 0,0, 1,0, 3,32'hB, 1,1);
        applyStimulus(v);
        checkVector("fwd push1", v);
        v = mk(1,1, 7,32'h22, 0,0, 1,0, 3,32'hB, 2,1);
        applyStimulus(v);
        checkVector("fwd push2", v);
        res_if.res_valid = 1'b0;
        fwd_ra = 5'd7;
        #1;
        checkOutput("fwd r7 hit",  32'(fwd_hit), 32'd1);
        checkOutput("fwd r7 data", fwd_data,     32'h22);
        fwd_ra = 5'd0;
        #1;
        checkOutput("fwd r0 hit",  32'(fwd_hit), 32'd0);
        checkOutput("fwd r0 data", fwd_data,     32'h0);
        fwd_ra = 5'd9;
        #1;
        checkOutput("fwd miss hit",  32'(fwd_hit), 32'd0);
        checkOutput("fwd miss data", fwd_data,     32'h0);
        // Older r7 moves to the output register; queue copy is still younger
        fwd_ra = 5'd7;
        v = mk(1,0, 0,32'h0, 1,0, 1,1, 7,32'h11, 1,1);
        applyStimulus(v);
        checkVector("fwd pop1", v);
        checkOutput("fwd pop1 data", fwd_data, 32'h22);
        // Only the output register holds r7 now
        v = mk(1,0, 0,32'h0, 1,0, 1,1, 7,32'h22, 0,1);
        applyStimulus(v);
        checkVector("fwd pop2", v);
        checkOutput("fwd outreg hit",  32'(fwd_hit), 32'd1);
        checkOutput("fwd outreg data", fwd_data,     32'h22);
        v = mk(1,0, 0,32'h0, 1,0, 1,0, 7,32'h22, 0,0);
        applyStimulus(v);
        checkVector("fwd idle", v);
        checkOutput("fwd retired hit", 32'(fwd_hit), 32'd0);
`endif

        // Asynchronous reset in the middle of a cycle with an entry queued
        v = mk(1,1,20,32'h1400, 0,0, 1,0, RFWA,RFWD, 1,1);
        applyStimulus(v);
        checkVector("pre-reset push", v);
        res_if.res_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset count",     32'(count),            32'd0);
        checkOutput("async reset res_ready", 32'(res_if.res_ready), 32'd0);
        checkOutput("async reset pending",   32'(pending),          32'd0);
        checkOutput("async reset RFWA",      32'(RFWA),             32'd0);
        checkOutput("async reset RFWD",      RFWD,                  32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("release res_ready", 32'(res_if.res_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
